// File: rtl/fmul_issue_ctrl_pkg.sv
// Shared definitions for the FP32 multiplier issue controller.
// Holds the FP32 operand width, the default multiplier latency and a few
// FP32 bit patterns that benches use when building operand vectors.
package fmul_issue_ctrl_pkg;

  localparam int unsigned FP32_W      = 32;
  localparam int unsigned MUL_LAT_DEF = 2;

  localparam logic [FP32_W-1:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [FP32_W-1:0] FP32_INF  = 32'h7F80_0000;

endpackage

// File: rtl/fmul_result_fifo.sv
// Synchronous result FIFO for the multiplier issue controller.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       synchronous clear; overrides push and pop in the same cycle
//   push        write push_data (must never occur while full)
//   push_data   entry to store
//   pop         drop the head entry (ignored while empty)
//   head_data   current head entry; zero while empty
//   empty       no entries stored
//   count       number of stored entries (0..DEPTH)
module fmul_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en, pop_en, full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign push_en = push & ~clear;
  assign pop_en  = pop & ~clear & ~empty;
  assign count   = count_q;

  // Head reads as zero when empty so idle outputs stay quiet after a clear.
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  // Issue credits reserve a slot for every in-flight op, so this cannot fire.
  push_while_full_a: assert property (@(posedge clk) disable iff (!rst_n) !(push_en && full))
    else $error("fmul_result_fifo: push while full");

endmodule

// File: rtl/fmul_issue_ctrl.sv
// Valid/ready front-end for a pipelined FP32 multiplier that has no stall or valid.
// Operand pairs are issued to the multiplier only when a result slot is guaranteed,
// a valid/tag shift register follows each op through the multiplier, and the
// result is captured into a small FIFO presented as a valid/ready stream.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   drop in-flight ops and queued results (synchronous)
//   in_valid/in_ready       operand handshake; in_a, in_b operands, in_tag user tag
//   mul_a, mul_b            operand bus to the multiplier (zero when not issuing)
//   mul_c, mul_err          product and error flag from the multiplier
//   out_valid/out_ready     result handshake; out_c, out_err, out_tag result fields
//   err_count               saturating count of captured results with mul_err set
module fmul_issue_ctrl
  import fmul_issue_ctrl_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned ERR_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP32_W-1:0] in_a,
  input  logic [FP32_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [FP32_W-1:0] mul_a,
  output logic [FP32_W-1:0] mul_b,
  input  logic [FP32_W-1:0] mul_c,
  input  logic              mul_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP32_W-1:0] out_c,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned RW = FP32_W + 1 + TAG_W;
  // One extra bit: fifo count plus in-flight ops may briefly be summed past DEPTH.
  localparam logic [CW:0] DepthL = (CW + 1)'(DEPTH);

  logic [MUL_LAT-1:0]            vld_sr_q, vld_sr_d;
  logic [MUL_LAT-1:0][TAG_W-1:0] tag_sr_q, tag_sr_d;
  logic [ERR_W-1:0]              err_count_q;
  logic [CW-1:0]                 fifo_count;
  logic [CW:0]                   occupancy;
  logic [RW-1:0]                 push_data, head_data;
  logic                          fifo_empty, fire, capture, pop;

  // Credits: every queued result and every op still in the multiplier holds a slot.
  // Uses registered state only, so there is no combinational out_ready -> in_ready path.
  always_comb begin
    occupancy = {1'b0, fifo_count};
    for (int i = 0; i < MUL_LAT; i++) begin
      occupancy = occupancy + (CW + 1)'(vld_sr_q[i]);
    end
  end

  assign in_ready = (occupancy < DepthL) & ~flush;
  assign fire     = in_valid & in_ready;
  assign mul_a    = fire ? in_a : '0;
  assign mul_b    = fire ? in_b : '0;

  always_comb begin
    vld_sr_d = '0;
    tag_sr_d = '0;
    if (!flush) begin
      vld_sr_d[0] = fire;
      tag_sr_d[0] = in_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        vld_sr_d[i] = vld_sr_q[i-1];
        tag_sr_d[i] = tag_sr_q[i-1];
      end
    end
  end

  assign capture   = vld_sr_q[MUL_LAT-1] & ~flush;
  assign push_data = {mul_c, mul_err, tag_sr_q[MUL_LAT-1]};
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign {out_c, out_err, out_tag} = head_data;
  assign err_count = err_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr_q    <= '0;
      tag_sr_q    <= '0;
      err_count_q <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
      tag_sr_q <= tag_sr_d;
      if (capture && mul_err && (err_count_q != '1)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

  fmul_result_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (capture),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
